// File: rtl/lc3_pkg.sv
// Shared types and encodings for the LC-3 microsequencer.
// States, opcodes and datapath mux-select values.
package lc3_pkg;

    typedef enum logic [4:0] {
        StHalted, StF1, StF2, StF3, StDec,
        StAdd, StAnd, StNot, StBrT, StJmp,
        StJ1, StJ2, StL1, StL2, StL3,
        StS1, StS2, StS3, StP1, StP2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC   = 2'd0;
    localparam logic [1:0] PCMUX_BUS   = 2'd1;
    localparam logic [1:0] PCMUX_ADDER = 2'd2;

    localparam logic [1:0] DRMUX_IR = 2'd0;
    localparam logic [1:0] DRMUX_R7 = 2'd1;

    localparam logic [1:0] SR1MUX_DR  = 2'd0;
    localparam logic [1:0] SR1MUX_SR1 = 2'd1;

    localparam logic [1:0] ADDR2MUX_ZERO  = 2'd0;
    localparam logic [1:0] ADDR2MUX_OFF6  = 2'd1;
    localparam logic [1:0] ADDR2MUX_OFF9  = 2'd2;
    localparam logic [1:0] ADDR2MUX_OFF11 = 2'd3;

    localparam logic [1:0] ALUK_ADD   = 2'd0;
    localparam logic [1:0] ALUK_AND   = 2'd1;
    localparam logic [1:0] ALUK_NOT   = 2'd2;
    localparam logic [1:0] ALUK_PASSA = 2'd3;

    function automatic logic is_mem_state(input state_t s);
        return (s == StF2) || (s == StL2) || (s == StS3);
    endfunction

endpackage

// File: rtl/lc3_wait_ctr.sv
// Memory-access wait counter: cleared while clr is high, counts up to MEM_WAIT-1
// and holds there with done asserted.
module lc3_wait_ctr #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    output logic done
);

    localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

    logic [2:0] cnt_q;

    always_ff @(posedge Clk) begin
        if (!Reset || clr) begin
            cnt_q <= '0;
        end else if (!done) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/lc3_control.sv
// LC-3 microsequencer: fetch/decode/execute FSM with Moore-decoded datapath controls.
// Optional PAUSE instruction (opcode 1101) enabled by defining LC3_PAUSE_EN.
module lc3_control
    import lc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_LED,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic [1:0]  DRMUX,
    output logic [1:0]  SR1MUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        MIO_EN,
    output logic        Mem_OE,
    output logic        Mem_WE
);

    state_t state_q, state_d;
    logic   done;

    // Counter sits at zero outside memory states, so every entry starts a fresh count.
    lc3_wait_ctr #(
        .MEM_WAIT(MEM_WAIT)
    ) u_wait_ctr (
        .Clk  (Clk),
        .Reset(Reset),
        .clr  (!is_mem_state(state_q)),
        .done (done)
    );

    logic unused_ir;
    assign unused_ir = ^{IR[11:6], IR[4:0]};
`ifndef LC3_PAUSE_EN
    logic unused_continue;
    assign unused_continue = Continue;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StHalted;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHalted: if (Run) state_d = StF1;
            StF1:     state_d = StF2;
            StF2:     if (done) state_d = StF3;
            StF3:     state_d = StDec;
            StDec: begin
                case (IR[15:12])
                    OP_ADD:   state_d = StAdd;
                    OP_AND:   state_d = StAnd;
                    OP_NOT:   state_d = StNot;
                    OP_BR:    state_d = BEN ? StBrT : StF1;
                    OP_JMP:   state_d = StJmp;
                    OP_JSR:   state_d = StJ1;
                    OP_LDR:   state_d = StL1;
                    OP_STR:   state_d = StS1;
`ifdef LC3_PAUSE_EN
                    OP_PAUSE: state_d = StP1;
`else
                    OP_PAUSE: state_d = StF1;
`endif
                    default:  state_d = StF1;
                endcase
            end
            StAdd, StAnd, StNot, StBrT, StJmp, StJ2, StL3: state_d = StF1;
            StJ1:     state_d = StJ2;
            StL1:     state_d = StL2;
            StL2:     if (done) state_d = StL3;
            StS1:     state_d = StS2;
            StS2:     state_d = StS3;
            StS3:     if (done) state_d = StF1;
`ifdef LC3_PAUSE_EN
            StP1:     if (Continue) state_d = StP2;
            StP2:     if (!Continue) state_d = StF1;
`endif
            default:  state_d = StHalted;
        endcase
    end

    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_INC;
        DRMUX      = DRMUX_IR;
        SR1MUX     = SR1MUX_DR;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2MUX_ZERO;
        ALUK       = ALUK_ADD;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        unique case (state_q)
            StF1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
                PCMUX  = PCMUX_INC;
            end
            StF2, StL2: begin
                Mem_OE = 1'b0;
                MIO_EN = 1'b1;
                LD_MDR = done;
            end
            StF3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            StDec: LD_BEN = 1'b1;
            StAdd, StAnd, StNot: begin
                SR1MUX  = SR1MUX_SR1;
                SR2MUX  = IR[5];
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                if (state_q == StAnd) begin
                    ALUK = ALUK_AND;
                end else if (state_q == StNot) begin
                    ALUK = ALUK_NOT;
                end
            end
            StBrT: begin
                ADDR2MUX = ADDR2MUX_OFF9;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            StJmp: begin
                SR1MUX  = SR1MUX_SR1;
                ALUK    = ALUK_PASSA;
                GateALU = 1'b1;
                PCMUX   = PCMUX_BUS;
                LD_PC   = 1'b1;
            end
            StJ1: begin
                GatePC = 1'b1;
                DRMUX  = DRMUX_R7;
                LD_REG = 1'b1;
            end
            StJ2: begin
                ADDR2MUX = ADDR2MUX_OFF11;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            StL1, StS1: begin
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2MUX_OFF6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            StL3: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            StS2: begin
                SR1MUX  = SR1MUX_DR;
                ALUK    = ALUK_PASSA;
                GateALU = 1'b1;
                MIO_EN  = 1'b0;
                LD_MDR  = 1'b1;
            end
            StS3: Mem_WE = 1'b0;
`ifdef LC3_PAUSE_EN
            StP1: LD_LED = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
